// File: rtl/delay_pipe.sv
// Tapped delay line: DEPTH data/valid stages with a selectable output tap.
// Tap 0 bypasses the registers; larger taps are clamped to the last stage.
module delay_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SELW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  occupancy
);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [SELW-1:0]  occ_next;
    logic [SELW-1:0]  selc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VALUE;
            v         <= '0;
            occupancy <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VALUE;
            v         <= '0;
            occupancy <= '0;
        end else if (en) begin
            d[0] <= in_data;
            v[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                d[k] <= d[k-1];
                v[k] <= v[k-1];
            end
            occupancy <= occ_next;
        end
    end

    // Count only moves when exactly one valid enters or leaves.
    always_comb begin
        occ_next = occupancy;
        unique case ({in_valid, v[DEPTH-1]})
            2'b10:   occ_next = occupancy + SELW'(1);
            2'b01:   occ_next = occupancy - SELW'(1);
            default: occ_next = occupancy;
        endcase
    end

    always_comb begin
        selc = sel;
        if (sel > SELW'(DEPTH)) selc = SELW'(DEPTH);
    end

    always_comb begin
        out_data  = in_data;
        out_valid = in_valid;
        for (int k = 0; k < DEPTH; k++) begin
            if (selc == SELW'(k + 1)) begin
                out_data  = d[k];
                out_valid = v[k];
            end
        end
    end

endmodule

// File: tb/tb_delay_pipe.sv
// Directed and short randomized checks for delay_pipe (WIDTH=8, DEPTH=4).
module tb_delay_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] md [4];
    logic [3:0] mv;

    delay_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: newest sample at index 0.
    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int k = 0; k < 4; k++) md[k] = 8'h00;
            mv = '0;
        end else if (en) begin
            for (int k = 3; k > 0; k--) begin
                md[k] = md[k-1];
                mv[k] = mv[k-1];
            end
            md[0] = in_data;
            mv[0] = in_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] dat, input logic vld);
        en       = 1'b1;
        in_valid = vld;
        in_data  = dat;
        tick();
    endtask

    logic [7:0] tap_exp [8];
    logic [7:0] exp_d;
    logic       exp_v;
    logic [7:0] hold_d;
    logic       hold_v;
    logic [2:0] hold_o;
    int         s;

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE; sel = 3'd4;
        tick();
        check("rst_occ", 32'(occupancy), 0);
        check("rst_v4", 32'(out_valid), 0);
        check("rst_d4", 32'(out_data), 0);
        sel = 3'd1; #1;
        check("rst_v1", 32'(out_valid), 0);
        check("rst_d1", 32'(out_data), 0);
        rst = 1'b0;

        // Basic delay through the full depth
        sel = 3'd4;
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), 1'b1);
            if (i == 3) begin
                check("lat_v3", 32'(out_valid), 0);
                check("lat_o3", 32'(occupancy), 3);
            end
            if (i == 4) begin
                check("lat_d4", 32'(out_data), 32'h01);
                check("lat_v4", 32'(out_valid), 1);
                check("lat_o4", 32'(occupancy), 4);
            end
        end
        check("steady_d", 32'(out_data), 32'h05);
        check("steady_o", 32'(occupancy), 4);

        // Stall holds everything and delays 0xA5 by the stall length
        push(8'hA5, 1'b1);
        en = 1'b0; in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_d", 32'(out_data), 32'h06);
            check("stall_v", 32'(out_valid), 1);
            check("stall_o", 32'(occupancy), 4);
        end
        push(8'h11, 1'b1);
        push(8'h12, 1'b1);
        check("stall_pre", 32'(out_data), 32'h08);
        push(8'h13, 1'b1);
        check("stall_a5", 32'(out_data), 32'hA5);

        // Tap sweep with clamp
        push(8'h10, 1'b1);
        push(8'h20, 1'b1);
        push(8'h30, 1'b1);
        push(8'h40, 1'b1);
        en = 1'b0; in_data = 8'h55; in_valid = 1'b1;
        tap_exp = '{8'h55, 8'h40, 8'h30, 8'h20, 8'h10, 8'h10, 8'h10, 8'h10};
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            check($sformatf("tap%0d", i), 32'(out_data), 32'(tap_exp[i]));
        end
        tick();
        check("tap_keep", 32'(out_data), 32'h10);

        // Clear wins over enable
        clr = 1'b1; en = 1'b1; in_data = 8'h99;
        tick();
        clr = 1'b0; en = 1'b0;
        check("clr_occ", 32'(occupancy), 0);
        for (int i = 1; i <= 4; i++) begin
            sel = 3'(i); #1;
            check($sformatf("clr_v%0d", i), 32'(out_valid), 0);
            check($sformatf("clr_d%0d", i), 32'(out_data), 0);
        end

        // Invalid data still moves
        push(8'h77, 1'b0);
        push(8'h88, 1'b1);
        en = 1'b0; sel = 3'd2; #1;
        check("inv_d", 32'(out_data), 32'h77);
        check("inv_v", 32'(out_valid), 0);
        check("inv_o", 32'(occupancy), 1);

        // Asynchronous reset between edges
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b1);
        en = 1'b0; sel = 3'd4;
        check("pre_rst_o", 32'(occupancy), 4);
        #2 rst = 1'b1;
        #1;
        check("arst_o", 32'(occupancy), 0);
        check("arst_v", 32'(out_valid), 0);
        check("arst_d", 32'(out_data), 0);
        #1 rst = 1'b0;
        push(8'h3C, 1'b1);
        sel = 3'd1; #1;
        check("post_d", 32'(out_data), 32'h3C);
        check("post_v", 32'(out_valid), 1);
        check("post_o", 32'(occupancy), 1);

        // Randomized regression against the model
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(3) != 0);
            clr      = ($urandom_range(31) == 0);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            sel      = 3'($urandom_range(7));
            #1;
            s = (sel > 3'd4) ? 4 : int'(sel);
            exp_d = (s == 0) ? in_data : md[s-1];
            exp_v = (s == 0) ? in_valid : mv[s-1];
            check("rnd_d", 32'(out_data), 32'(exp_d));
            check("rnd_v", 32'(out_valid), 32'(exp_v));
            check("rnd_occ", 32'(occupancy), 32'($countones(mv)));
            hold_d = out_data; hold_v = out_valid; hold_o = occupancy;
            tick();
            if (!en && !clr) begin
                check("hold_d", 32'(out_data), 32'(hold_d));
                check("hold_v", 32'(out_valid), 32'(hold_v));
                check("hold_o", 32'(occupancy), 32'(hold_o));
            end
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
